// File: rtl/popcount_seq_pkg.sv
// Shared types and parameter helpers for the multi-cycle popcount sequencer.
package popcount_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int num_chunks(input int data_w, input int chunk_w);
        return (data_w + chunk_w - 1) / chunk_w;
    endfunction

    // Width able to hold every value from 0 to w inclusive.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/popcount_seq_popcount.sv
// Combinational population count of one slice, shared by the sequencer.
module popcount
    import popcount_seq_pkg::*;
#(
    parameter int  INPUT_WIDTH = 16,
    localparam int OUT_W       = cnt_width(INPUT_WIDTH)
) (
    input  logic [INPUT_WIDTH-1:0] data_i,
    output logic [OUT_W-1:0]       count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < INPUT_WIDTH; i++) begin
            count_o = count_o + OUT_W'(data_i[i]);
        end
    end

endmodule

// File: rtl/popcount_seq.sv
// Multi-cycle popcount: captures a vector, walks it one CHUNK_WIDTH slice per cycle
// through a single popcount unit, and returns the accumulated total over valid/ready.
module popcount_seq
    import popcount_seq_pkg::*;
#(
    parameter int  DATA_WIDTH  = 64,
    parameter int  CHUNK_WIDTH = 16,
    localparam int CNT_W       = cnt_width(DATA_WIDTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [CNT_W-1:0]      popcount_o,
    output logic                  busy_o
);

    localparam int NUM_CHUNKS  = num_chunks(DATA_WIDTH, CHUNK_WIDTH);
    localparam int PAD_WIDTH   = NUM_CHUNKS * CHUNK_WIDTH;
    localparam int IDX_W       = idx_width(NUM_CHUNKS);
    localparam int SLICE_CNT_W = cnt_width(CHUNK_WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

    state_e                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic [CNT_W-1:0]       acc_q, acc_d;
    logic [CNT_W-1:0]       result_q, result_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [CNT_W-1:0]       acc_sum;
    logic [PAD_WIDTH-1:0]   data_pad;
    logic [CHUNK_WIDTH-1:0] slice;
    logic [SLICE_CNT_W-1:0] slice_cnt;
    logic                   last_slice;

    // Bits above DATA_WIDTH are constant zero, so the final slice is zero-padded.
    always_comb begin
        data_pad                 = '0;
        data_pad[DATA_WIDTH-1:0] = data_q;
    end

    assign slice      = data_pad[int'(idx_q) * CHUNK_WIDTH +: CHUNK_WIDTH];
    assign last_slice = (idx_q == LAST_IDX);

    popcount #(
        .INPUT_WIDTH (CHUNK_WIDTH)
    ) i_popcount (
        .data_i  (slice),
        .count_o (slice_cnt)
    );

    assign acc_sum = acc_q + CNT_W'(slice_cnt);

    always_comb begin
        // NOTE: every _d gets a hold default first so no path through the case infers a latch.
        state_d  = state_q;
        data_d   = data_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        result_d = result_q;

        unique case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    data_d  = data_i;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                acc_d = acc_sum;
                idx_d = idx_q + IDX_W'(1);
                if (last_slice) begin
                    result_d = acc_sum;
                    idx_d    = '0;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flush overrides both handshakes; an IDLE accept is suppressed the same way.
        if (flush_i) begin
            state_d = ST_IDLE;
            data_d  = data_q;
            acc_d   = '0;
            idx_d   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            // NOTE: the data register is reset too so popcount never sees stale X on the slice mux.
            data_q   <= '0;
            acc_q    <= '0;
            idx_q    <= '0;
            result_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so all state updates see pre-edge values.
            state_q  <= state_d;
            data_q   <= data_d;
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            result_q <= result_d;
        end
    end

    assign ready_o    = (state_q == ST_IDLE);
    assign valid_o    = (state_q == ST_DONE);
    assign busy_o     = (state_q != ST_IDLE);
    assign popcount_o = result_q;

    a_valid_in_done : assert property (@(posedge clk_i)
        !valid_o || (state_q == ST_DONE));
    a_result_stable : assert property (@(posedge clk_i)
        (rst_ni && valid_o && !ready_i) |=> (!rst_ni || $stable(popcount_o)));
    a_acc_bounded   : assert property (@(posedge clk_i)
        acc_q <= CNT_W'(DATA_WIDTH));

endmodule

// File: tb/tb_popcount_seq.sv
// Directed and randomized checks of popcount_seq in three geometries against $countones.
module tb_popcount_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    // 64-bit vector, 16-bit slices
    logic        a_flush = 1'b0, a_valid = 1'b0, a_ready_i = 1'b0;
    logic [63:0] a_data = '0;
    logic        a_ready_o, a_valid_o, a_busy_o;
    logic [6:0]  a_pop;

    // 981-bit vector, 64-bit slices, padded last slice
    logic         b_flush = 1'b0, b_valid = 1'b0, b_ready_i = 1'b0;
    logic [980:0] b_data = '0;
    logic         b_ready_o, b_valid_o, b_busy_o;
    logic [10:0]  b_pop;

    // single-bit vector, single-bit slice
    logic       c_flush = 1'b0, c_valid = 1'b0, c_ready_i = 1'b0;
    logic [0:0] c_data = '0;
    logic       c_ready_o, c_valid_o, c_busy_o;
    logic [0:0] c_pop;

    popcount_seq #(.DATA_WIDTH(64), .CHUNK_WIDTH(16)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush), .valid_i(a_valid),
        .ready_o(a_ready_o), .data_i(a_data), .valid_o(a_valid_o),
        .ready_i(a_ready_i), .popcount_o(a_pop), .busy_o(a_busy_o)
    );

    popcount_seq #(.DATA_WIDTH(981), .CHUNK_WIDTH(64)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush), .valid_i(b_valid),
        .ready_o(b_ready_o), .data_i(b_data), .valid_o(b_valid_o),
        .ready_i(b_ready_i), .popcount_o(b_pop), .busy_o(b_busy_o)
    );

    popcount_seq #(.DATA_WIDTH(1), .CHUNK_WIDTH(1)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(c_flush), .valid_i(c_valid),
        .ready_o(c_ready_o), .data_i(c_data), .valid_o(c_valid_o),
        .ready_i(c_ready_i), .popcount_o(c_pop), .busy_o(c_busy_o)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One job on the 64-bit instance; optionally holds valid_i high with other data
    // while busy and keeps ready_i low for `hold` cycles in DONE.
    task automatic a_job(input logic [63:0] d, input int hold, input bit keep_valid,
                         input string tag);
        int         lat;
        logic [6:0] exp_cnt;
        exp_cnt = 7'($countones(d));
        a_data  = d;
        a_valid = 1'b1;
        step();
        a_valid = keep_valid;
        a_data  = ~d;
        lat = 0;
        while (a_valid_o !== 1'b1 && lat < 20) begin
            step();
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'd4);
        chk({tag, " count"}, 64'(a_pop), 64'(exp_cnt));
        chk({tag, " ready_o/busy_o in DONE"}, {a_ready_o, a_busy_o}, 64'b01);
        for (int i = 0; i < hold; i++) begin
            step();
            chk($sformatf("%s hold %0d", tag, i), {a_valid_o, a_ready_o, a_pop},
                {1'b1, 1'b0, exp_cnt});
        end
        a_valid   = 1'b0;
        a_ready_i = 1'b1;
        step();
        a_ready_i = 1'b0;
        chk({tag, " back to IDLE"}, {a_ready_o, a_valid_o, a_busy_o, a_pop},
            {1'b1, 1'b0, 1'b0, exp_cnt});
    endtask

    task automatic b_job(input logic [980:0] d, input string tag);
        int lat;
        b_data  = d;
        b_valid = 1'b1;
        step();
        b_valid = 1'b0;
        lat = 0;
        while (b_valid_o !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'd16);
        chk({tag, " count"}, 64'(b_pop), 64'($countones(d)));
        b_ready_i = 1'b1;
        step();
        b_ready_i = 1'b0;
        chk({tag, " back to IDLE"}, {b_ready_o, b_valid_o}, 64'b10);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [980:0]  vec;
        logic [0:0]    sb[$];
        logic          seen;
        int            dens, sent, got, cyc;
        bit            acc_now;

        // Reset
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("reset a", {a_ready_o, a_valid_o, a_busy_o, a_pop}, {1'b1, 1'b0, 1'b0, 7'd0});
        chk("reset b", {b_ready_o, b_valid_o, b_busy_o, b_pop}, {1'b1, 1'b0, 1'b0, 11'd0});
        chk("reset c", {c_ready_o, c_valid_o, c_busy_o, c_pop}, {1'b1, 1'b0, 1'b0, 1'b0});

        // Single-chunk geometry: result one cycle after accept
        c_data  = 1'b1;
        c_valid = 1'b1;
        step();
        c_valid = 1'b0;
        chk("c1 busy after accept", {c_valid_o, c_busy_o, c_ready_o}, 64'b010);
        step();
        chk("c1 result", {c_valid_o, c_pop}, 64'b11);
        c_ready_i = 1'b1;
        step();
        c_ready_i = 1'b0;
        chk("c1 back to IDLE", {c_ready_o, c_valid_o}, 64'b10);

        // Full-ones, then two ones with backpressure and valid_i held high while busy
        a_job(64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0, "a ones");
        a_job(64'h8000_0000_0000_0001, 10, 1'b1, "a ends");

        // Flush while BUSY: no result, accumulator restarts clean
        a_data  = 64'hF0F0_F0F0_F0F0_F0F0;
        a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        step();
        a_flush = 1'b1;
        step();
        a_flush = 1'b0;
        chk("flush busy -> idle", {a_ready_o, a_valid_o, a_busy_o}, 64'b100);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            seen = seen | a_valid_o;
        end
        chk("flush busy no valid_o", 64'(seen), 64'd0);
        a_job(64'h1, 0, 1'b0, "a after flush");

        // Flush while DONE drops valid_o
        a_data  = 64'h0000_0000_0000_00FF;
        a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        for (int i = 0; i < 20 && a_valid_o !== 1'b1; i++) step();
        chk("flush done precondition", 64'(a_valid_o), 64'd1);
        a_flush   = 1'b1;
        a_ready_i = 1'b1;
        step();
        a_flush   = 1'b0;
        a_ready_i = 1'b0;
        chk("flush done -> idle", {a_ready_o, a_valid_o, a_busy_o}, 64'b100);

        // Flush in IDLE blocks the handshake that cycle
        a_data  = 64'h0000_0000_0000_0007;
        a_valid = 1'b1;
        a_flush = 1'b1;
        step();
        a_flush = 1'b0;
        chk("flush idle blocks accept", {a_ready_o, a_busy_o}, 64'b10);
        a_job(64'h0000_0000_0000_0007, 0, 1'b0, "a after idle flush");

        // Padded geometry: directed corners then random densities
        b_job('1, "b ones");
        b_job(981'd1, "b one");
        b_job('0, "b zero");
        for (int j = 0; j < 100; j++) begin
            dens = $urandom_range(0, 100);
            for (int i = 0; i < 981; i++) vec[i] = ($urandom_range(0, 99) < dens);
            b_job(vec, $sformatf("b rand %0d", j));
        end

        // Single-bit geometry with random handshakes against a scoreboard
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < 200 && cyc < 8000) begin
            c_ready_i = 1'($urandom_range(0, 1));
            if (!c_valid && sent < 200 && $urandom_range(0, 2) != 0) begin
                c_valid = 1'b1;
                c_data  = 1'($urandom_range(0, 1));
            end
            acc_now = c_valid && c_ready_o;
            if (acc_now) begin
                sb.push_back(c_data);
                sent++;
            end
            if (c_valid_o && c_ready_i) begin
                chk("c no duplicate", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) chk($sformatf("c job %0d", got), 64'(c_pop), 64'(sb.pop_front()));
                got++;
            end
            step();
            cyc++;
            if (acc_now) c_valid = 1'b0;
        end
        chk("c results delivered", 64'(got), 64'd200);
        chk("c jobs accepted", 64'(sent), 64'd200);
        chk("c scoreboard drained", 64'(sb.size()), 64'd0);

        // Reset mid-job discards the job
        a_data  = 64'hFFFF_0000_FFFF_0000;
        a_valid = 1'b1;
        step();
        a_valid = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("reset mid-job", {a_ready_o, a_valid_o, a_busy_o, a_pop}, {1'b1, 1'b0, 1'b0, 7'd0});
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            seen = seen | a_valid_o;
        end
        chk("reset mid-job no valid_o", 64'(seen), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
